// File: rtl/mips_pkg.sv
// mips_pkg: ALU control codes and multiply unit state encoding shared across the datapath
package mips_pkg;
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_MULT = 3'b011;
  localparam logic [2:0] ALU_MFHI = 3'b100;
  localparam logic [2:0] ALU_MFLO = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} mult_state_e;
  // codes that belong to the multiply unit and therefore interlock while busy
  function automatic logic is_unit_op(input logic [2:0] code);
    return code == ALU_MULT || code == ALU_MFHI || code == ALU_MFLO;
  endfunction
endpackage

// File: rtl/mult_seq_core.sv
// mult_seq_core: unsigned radix-2 shift-add multiplier, one multiplier bit per cycle
module mult_seq_core #(
  parameter int width = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [width-1:0]     mag_a,
  input  logic [width-1:0]     mag_b,
  output logic [2*width-1:0]   acc,
  output logic                 done
);
  localparam int cw = width > 1 ? $clog2(width) : 1;
  logic [2*width-1:0] mcand;
  logic [width-1:0]   mplier;
  logic [cw-1:0]      cnt;
  logic               run;
  // done marks the final iteration; the accumulator holds the full product on the next cycle
  assign done = run && cnt == '0;
  // load magnitudes on start, then add-and-shift once per cycle until the counter expires
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      run    <= 1'b0;
    end else if (start) begin
      mcand  <= {{width{1'b0}}, mag_a};
      mplier <= mag_b;
      acc    <= '0;
      cnt    <= cw'(width - 1);
      run    <= 1'b1;
    end else if (run) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
      run    <= !done;
    end
  end
endmodule

// File: rtl/mult_hilo_unit.sv
// mult_hilo_unit: sequential signed multiplier with HI/LO registers and PC interlock
module mult_hilo_unit
  import mips_pkg::*;
#(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [2:0]       ALUControl,
  input  logic [width-1:0] SrcA,
  input  logic [width-1:0] SrcB,
  output logic [width-1:0] Result,
  output logic             stall,
  output logic             busy,
  output logic [width-1:0] HI,
  output logic [width-1:0] LO
);
  mult_state_e        state, state_next;
  logic               neg, start, done, unit_op;
  logic [width-1:0]   mag_a, mag_b;
  logic [2*width-1:0] acc, prod;
  assign unit_op = op_valid && is_unit_op(ALUControl);
  assign busy    = state != ST_IDLE;
  assign stall   = unit_op && busy;
  assign start   = op_valid && ALUControl == ALU_MULT && !busy;
  // the most negative value negates to itself, which is exactly its unsigned magnitude
  assign mag_a   = SrcA[width-1] ? -SrcA : SrcA;
  assign mag_b   = SrcB[width-1] ? -SrcB : SrcB;
  assign prod    = neg ? -acc : acc;
  assign Result  = !op_valid ? '0 : ALUControl == ALU_MFHI ? HI : ALUControl == ALU_MFLO ? LO : '0;
  mult_seq_core #(.width(width)) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mag_a (mag_a),
    .mag_b (mag_b),
    .acc   (acc),
    .done  (done)
  );
  // next state: accept a mult in idle, leave run after the last iteration, fix lasts one cycle
  always_comb begin
    state_next = state;
    state_next = state == ST_IDLE ? (start ? ST_RUN : ST_IDLE) :
                 state == ST_RUN  ? (done  ? ST_FIX : ST_RUN)  : ST_IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else state <= state_next;
  end
  // remember the product sign for the correction step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) neg <= 1'b0;
    else if (start) neg <= SrcA[width-1] ^ SrcB[width-1];
  end
  // HI/LO change only in the fix cycle, so readers never see a partial product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      HI <= '0;
      LO <= '0;
    end else if (state == ST_FIX) begin
      HI <= prod[2*width-1:width];
      LO <= prod[width-1:0];
    end
  end
endmodule
